gumnut_alu_seq: RTL and testbench
=================================

GUMNUT_ALU_SEQ -- requirements
Module: gumnut_alu_seq

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command offered.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_op_i  in  4  ALU action code:
  - bit3=1: shift.
  - bit3=0, bit2=1: logic.
  - else: arithmetic.
- cmd_len_i  in  2  operand bytes minus one (1..4 bytes).
- cmd_a_i  in  32  first operand, byte 0 = LSB.
- cmd_b_i  in  32  second operand.
- cmd_cnt_i  in  3  shift count.
- cmd_cin_i  in  1  carry-in for byte 0.
- rsp_valid_o  out  1  result available.
- rsp_ready_i  in  1  result consumed.
- rsp_res_o  out  32  result.
- rsp_z_o / rsp_c_o / rsp_v_o / rsp_n_o  out  1 each  flags.
- rsp_err_o  out  1  illegal command.
- busy_o  out  1  not IDLE.
- alu_rs_o, alu_op2_o  out  8  ALU operand bytes.
- alu_count_o  out  3  ALU shift count.
- alu_carry_o  out  1  ALU carry-in.
- alu_s_o  out  4  ALU action select.
- alu_res_i  in  8  ALU result.
- alu_carry_i, alu_ovf_i, alu_nf_i  in  1  ALU flags.

Function
REQ-002 SHALL implement FSM states IDLE, RUN, DONE; busy_o=1 in RUN and DONE.
REQ-003 cmd_ready_o SHALL be 1 only in IDLE; acceptance latches op, len, operands, cnt, cin and clears result register.
REQ-004 Legal acceptance SHALL transition IDLE->RUN with byte index idx=0.
REQ-005 A shift op with cmd_len_i!=0 SHALL be illegal: IDLE->DONE, rsp_err_o=1, result 0, all flags 0.
REQ-006 In RUN, the block SHALL drive:
- alu_rs_o = byte idx of A.
- alu_op2_o = byte idx of B.
- alu_count_o = cnt.
REQ-007 alu_s_o SHALL be the latched op, except arithmetic ops at idx>0, which drive {op[3:1],1'b1} (carry-using variant).
REQ-008 alu_carry_o SHALL be:
- latched cin at idx=0.
- for arithmetic at idx>0, alu_carry_i captured at the previous byte.
REQ-009 Each RUN edge SHALL write alu_res_i into result byte idx and increment idx.
REQ-010 Bytes above len SHALL read 0 in rsp_res_o.
REQ-011 On the edge capturing byte idx==len, the FSM SHALL go to DONE with rsp_valid_o=1; response latency is len+1 cycles after the acceptance edge.
REQ-012 Final flags:
- Z = 1 iff all len+1 captured bytes are 0.
- N = alu_nf_i of last byte.
- C = alu_carry_i of last byte.
- V = alu_ovf_i of last byte.
- Logic ops: C and V are passed through from the ALU (0).
REQ-013 Outside RUN, ALU drive outputs SHALL be 0 except alu_s_o, which holds the latched op.
REQ-014 DONE SHALL hold rsp_* stable until rsp_valid_o && rsp_ready_i, then go to IDLE; rsp_valid_o=0 in IDLE/RUN.
REQ-015 cmd_valid_i while busy SHALL be ignored, with no queuing.
REQ-016 idx SHALL be 2 bits and never wrap past len.

Reset
REQ-017 rst_ni low SHALL asynchronously force IDLE, and all registers and outputs to 0; cmd_ready_o=1 after release.
REQ-018 Reset during RUN or DONE SHALL abort the command with no response.

Verification
REQ-019 The bench SHALL cover:
- 2-byte add: op=0000, len=1, A=0x00FF, B=0x0001, cin=0 -> byte1 alu_s_o=0001, alu_carry_o=1; rsp after 2 cycles, res=0x00000100, Z=0, C=0.
- 4-byte add: A=0xFFFFFFFF, B=0x00000001 -> res=0, Z=1, C=1; rsp_valid_o 4 cycles after acceptance.
- Shift op=1000 with len=2 -> DONE next cycle, rsp_err_o=1, res=0.
- 1-byte logic op=0100 (AND): A=0xF0, B=0x0F -> res=0, Z=1, C=0, V=0.
- rsp_ready_i held low 5 cycles -> outputs stable, cmd_ready_o=0, new cmd_valid_i ignored.
- rst_ni low mid-RUN of a 4-byte op -> immediate IDLE, all outputs 0, no rsp_valid_o.

Source files
------------

// File: rtl/gumnut_alu_seq.sv
// Byte-serial sequencer for an external 8-bit Gumnut-style ALU: feeds operand bytes LSB first,
// chains carry across bytes and assembles a 1..4 byte result with flags.
module gumnut_alu_seq (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [3:0]  cmd_op_i,
    input  logic [1:0]  cmd_len_i,
    input  logic [31:0] cmd_a_i,
    input  logic [31:0] cmd_b_i,
    input  logic [2:0]  cmd_cnt_i,
    input  logic        cmd_cin_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_res_o,
    output logic        rsp_z_o,
    output logic        rsp_c_o,
    output logic        rsp_v_o,
    output logic        rsp_n_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic [7:0]  alu_rs_o,
    output logic [7:0]  alu_op2_o,
    output logic [2:0]  alu_count_o,
    output logic        alu_carry_o,
    output logic [3:0]  alu_s_o,
    input  logic [7:0]  alu_res_i,
    input  logic        alu_carry_i,
    input  logic        alu_ovf_i,
    input  logic        alu_nf_i
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q;
    logic [3:0]  op_q;
    logic [1:0]  len_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [2:0]  cnt_q;
    logic        cin_q;
    logic [1:0]  idx_q;
    logic [31:0] res_q;
    logic        carry_q;
    logic        zacc_q;
    logic        z_q;
    logic        c_q;
    logic        v_q;
    logic        n_q;
    logic        err_q;

    logic        run;
    logic        is_arith;
    logic [4:0]  bit_base;

    assign run      = (state_q == StRun);
    assign is_arith = ~op_q[3] & ~op_q[2];
    assign bit_base = {idx_q, 3'b000};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            op_q    <= 4'h0;
            len_q   <= 2'd0;
            a_q     <= 32'h0;
            b_q     <= 32'h0;
            cnt_q   <= 3'd0;
            cin_q   <= 1'b0;
            idx_q   <= 2'd0;
            res_q   <= 32'h0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        op_q    <= cmd_op_i;
                        len_q   <= cmd_len_i;
                        a_q     <= cmd_a_i;
                        b_q     <= cmd_b_i;
                        cnt_q   <= cmd_cnt_i;
                        cin_q   <= cmd_cin_i;
                        idx_q   <= 2'd0;
                        res_q   <= 32'h0;
                        carry_q <= 1'b0;
                        zacc_q  <= 1'b1;
                        z_q     <= 1'b0;
                        c_q     <= 1'b0;
                        v_q     <= 1'b0;
                        n_q     <= 1'b0;
                        // Shifts are single-byte only; wider requests fail without touching the ALU
                        if (cmd_op_i[3] && (cmd_len_i != 2'd0)) begin
                            err_q   <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            err_q   <= 1'b0;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    res_q[bit_base +: 8] <= alu_res_i;
                    carry_q              <= alu_carry_i;
                    zacc_q               <= zacc_q & (alu_res_i == 8'h00);
                    if (idx_q == len_q) begin
                        z_q     <= zacc_q & (alu_res_i == 8'h00);
                        c_q     <= alu_carry_i;
                        v_q     <= alu_ovf_i;
                        n_q     <= alu_nf_i;
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 2'd1;
                    end
                end
                StDone: begin
                    if (rsp_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        alu_rs_o    = 8'h00;
        alu_op2_o   = 8'h00;
        alu_count_o = 3'd0;
        alu_carry_o = 1'b0;
        alu_s_o     = op_q;
        if (run) begin
            alu_rs_o    = a_q[bit_base +: 8];
            alu_op2_o   = b_q[bit_base +: 8];
            alu_count_o = cnt_q;
            if (idx_q == 2'd0) begin
                alu_carry_o = cin_q;
            end else if (is_arith) begin
                // Upper bytes use the carry-consuming variant fed by the previous byte's carry
                alu_s_o     = {op_q[3:1], 1'b1};
                alu_carry_o = carry_q;
            end
        end
    end

    // Gated by reset so every output reads 0 while reset is asserted
    assign cmd_ready_o = (state_q == StIdle) & rst_ni;
    assign busy_o      = (state_q != StIdle);
    assign rsp_valid_o = (state_q == StDone);
    assign rsp_res_o   = res_q;
    assign rsp_z_o     = z_q;
    assign rsp_c_o     = c_q;
    assign rsp_v_o     = v_q;
    assign rsp_n_o     = n_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_gumnut_alu_seq.sv
// Directed bench for gumnut_alu_seq with a small behavioural 8-bit ALU attached to the ALU port.
module tb_gumnut_alu_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [3:0]  cmd_op_i = 4'h0;
    logic [1:0]  cmd_len_i = 2'd0;
    logic [31:0] cmd_a_i = 32'h0;
    logic [31:0] cmd_b_i = 32'h0;
    logic [2:0]  cmd_cnt_i = 3'd0;
    logic        cmd_cin_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_res_o;
    logic        rsp_z_o, rsp_c_o, rsp_v_o, rsp_n_o, rsp_err_o;
    logic        busy_o;
    logic [7:0]  alu_rs_o, alu_op2_o;
    logic [2:0]  alu_count_o;
    logic        alu_carry_o;
    logic [3:0]  alu_s_o;
    logic [7:0]  alu_res_i;
    logic        alu_carry_i, alu_ovf_i, alu_nf_i;

    int n_vec = 0;
    int n_err = 0;

    gumnut_alu_seq dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_len_i   (cmd_len_i),
        .cmd_a_i     (cmd_a_i),
        .cmd_b_i     (cmd_b_i),
        .cmd_cnt_i   (cmd_cnt_i),
        .cmd_cin_i   (cmd_cin_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_res_o   (rsp_res_o),
        .rsp_z_o     (rsp_z_o),
        .rsp_c_o     (rsp_c_o),
        .rsp_v_o     (rsp_v_o),
        .rsp_n_o     (rsp_n_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o),
        .alu_rs_o    (alu_rs_o),
        .alu_op2_o   (alu_op2_o),
        .alu_count_o (alu_count_o),
        .alu_carry_o (alu_carry_o),
        .alu_s_o     (alu_s_o),
        .alu_res_i   (alu_res_i),
        .alu_carry_i (alu_carry_i),
        .alu_ovf_i   (alu_ovf_i),
        .alu_nf_i    (alu_nf_i)
    );

    always #5 clk_i = ~clk_i;

    // ALU model: s[3] shift-left, s[2] logic (and/or/xor/not), else add/sub with s[0]=use carry
    logic [7:0] m_opb;
    logic       m_cin;
    always_comb begin
        alu_res_i   = 8'h00;
        alu_carry_i = 1'b0;
        alu_ovf_i   = 1'b0;
        m_opb       = 8'h00;
        m_cin       = 1'b0;
        if (alu_s_o[3]) begin
            alu_res_i = alu_rs_o << alu_count_o;
        end else if (alu_s_o[2]) begin
            case (alu_s_o[1:0])
                2'd0:    alu_res_i = alu_rs_o & alu_op2_o;
                2'd1:    alu_res_i = alu_rs_o | alu_op2_o;
                2'd2:    alu_res_i = alu_rs_o ^ alu_op2_o;
                default: alu_res_i = ~alu_rs_o;
            endcase
        end else begin
            m_opb = alu_s_o[1] ? ~alu_op2_o : alu_op2_o;
            m_cin = alu_s_o[0] ? alu_carry_o : 1'b0;
            {alu_carry_i, alu_res_i} = {1'b0, alu_rs_o} + {1'b0, m_opb} + {8'h00, m_cin};
            alu_ovf_i = (alu_rs_o[7] == m_opb[7]) && (alu_res_i[7] != alu_rs_o[7]);
        end
    end
    assign alu_nf_i = alu_res_i[7];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] len, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] cnt, input logic cin);
        cmd_op_i    = op;
        cmd_len_i   = len;
        cmd_a_i     = a;
        cmd_b_i     = b;
        cmd_cnt_i   = cnt;
        cmd_cin_i   = cin;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if ({cmd_ready_o, busy_o, rsp_valid_o, rsp_res_o, alu_s_o} !== 39'h0) begin
            n_err++;
            $display("FAIL reset_held: got %h want 0",
                     {cmd_ready_o, busy_o, rsp_valid_o, rsp_res_o, alu_s_o});
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        n_vec++;
        if ({cmd_ready_o, busy_o, rsp_valid_o} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_release: got %b want 100", {cmd_ready_o, busy_o, rsp_valid_o});
        end
        n_vec++;
        if ({alu_rs_o, alu_op2_o, alu_count_o, alu_carry_o, rsp_err_o} !== 21'h0) begin
            n_err++;
            $display("FAIL reset_alu: got %h want 0",
                     {alu_rs_o, alu_op2_o, alu_count_o, alu_carry_o, rsp_err_o});
        end
    endtask

    task automatic test_add2();
        issue(4'b0000, 2'd1, 32'h0000_00FF, 32'h0000_0001, 3'd0, 1'b0);
        n_vec++;
        if ({busy_o, cmd_ready_o, rsp_valid_o} !== 3'b100) begin
            n_err++;
            $display("FAIL add2_run: got %b want 100", {busy_o, cmd_ready_o, rsp_valid_o});
        end
        n_vec++;
        if ({alu_rs_o, alu_op2_o, alu_s_o, alu_carry_o} !== {8'hFF, 8'h01, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL add2_byte0: got %h want ff0100",
                     {alu_rs_o, alu_op2_o, alu_s_o, alu_carry_o});
        end
        tick();
        n_vec++;
        if ({alu_s_o, alu_carry_o, rsp_valid_o} !== {4'b0001, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL add2_byte1: got %b want 000110", {alu_s_o, alu_carry_o, rsp_valid_o});
        end
        tick();
        n_vec++;
        if (rsp_valid_o !== 1'b1 || rsp_res_o !== 32'h0000_0100) begin
            n_err++;
            $display("FAIL add2_rsp: got v=%b res=%h want v=1 res=00000100", rsp_valid_o, rsp_res_o);
        end
        n_vec++;
        if ({rsp_err_o, rsp_z_o, rsp_c_o, rsp_v_o, rsp_n_o} !== 5'b00000) begin
            n_err++;
            $display("FAIL add2_flags: got %b want 00000",
                     {rsp_err_o, rsp_z_o, rsp_c_o, rsp_v_o, rsp_n_o});
        end
        handshake();
        n_vec++;
        if ({cmd_ready_o, busy_o, rsp_valid_o, alu_s_o} !== {3'b100, 4'b0000}) begin
            n_err++;
            $display("FAIL add2_idle: got %b want 1000000",
                     {cmd_ready_o, busy_o, rsp_valid_o, alu_s_o});
        end
    endtask

    task automatic test_shift();
        issue(4'b1000, 2'd2, 32'h1234_5678, 32'h0, 3'd3, 1'b0);
        n_vec++;
        if ({rsp_valid_o, rsp_err_o, busy_o, rsp_res_o} !== {3'b111, 32'h0}) begin
            n_err++;
            $display("FAIL shift_err: got v/err/busy=%b res=%h want 111 res=0",
                     {rsp_valid_o, rsp_err_o, busy_o}, rsp_res_o);
        end
        n_vec++;
        if ({rsp_z_o, rsp_c_o, rsp_v_o, rsp_n_o, alu_rs_o, alu_count_o, alu_s_o}
            !== {4'b0000, 8'h00, 3'd0, 4'b1000}) begin
            n_err++;
            $display("FAIL shift_err_outs: got %h want 0008",
                     {rsp_z_o, rsp_c_o, rsp_v_o, rsp_n_o, alu_rs_o, alu_count_o, alu_s_o});
        end
        handshake();
        issue(4'b1000, 2'd0, 32'h0000_0003, 32'h0, 3'd2, 1'b0);
        n_vec++;
        if ({alu_rs_o, alu_count_o, alu_s_o} !== {8'h03, 3'd2, 4'b1000}) begin
            n_err++;
            $display("FAIL shift_drive: got %h want 03/2/8", {alu_rs_o, alu_count_o, alu_s_o});
        end
        tick();
        n_vec++;
        if ({rsp_valid_o, rsp_err_o, rsp_res_o} !== {2'b10, 32'h0000_000C}) begin
            n_err++;
            $display("FAIL shift_res: got v/err=%b res=%h want 10 res=0000000c",
                     {rsp_valid_o, rsp_err_o}, rsp_res_o);
        end
        handshake();
    endtask

    task automatic test_add4();
        int cycles;
        issue(4'b0000, 2'd3, 32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 1'b0);
        cycles = 0;
        while (rsp_valid_o !== 1'b1 && cycles < 10) begin
            tick();
            cycles++;
        end
        n_vec++;
        if (cycles !== 4) begin
            n_err++;
            $display("FAIL add4_latency: got %0d cycles want 4", cycles);
        end
        n_vec++;
        if (rsp_res_o !== 32'h0 || {rsp_z_o, rsp_c_o, rsp_v_o, rsp_n_o} !== 4'b1100) begin
            n_err++;
            $display("FAIL add4_rsp: got res=%h zcvn=%b want res=0 zcvn=1100",
                     rsp_res_o, {rsp_z_o, rsp_c_o, rsp_v_o, rsp_n_o});
        end
        n_vec++;
        if ({alu_rs_o, alu_carry_o, alu_s_o} !== 13'h0) begin
            n_err++;
            $display("FAIL add4_done_alu: got %h want 0", {alu_rs_o, alu_carry_o, alu_s_o});
        end
        handshake();
    endtask

    task automatic test_logic();
        issue(4'b0100, 2'd0, 32'h0000_00F0, 32'h0000_000F, 3'd0, 1'b1);
        tick();
        n_vec++;
        if (rsp_res_o !== 32'h0 || {rsp_valid_o, rsp_z_o, rsp_c_o, rsp_v_o} !== 4'b1100) begin
            n_err++;
            $display("FAIL and_rsp: got res=%h vzcv=%b want res=0 vzcv=1100",
                     rsp_res_o, {rsp_valid_o, rsp_z_o, rsp_c_o, rsp_v_o});
        end
        handshake();
        issue(4'b0101, 2'd1, 32'hAB00_1200, 32'h0000_0034, 3'd0, 1'b0);
        tick();
        n_vec++;
        if ({alu_s_o, alu_carry_o, alu_rs_o} !== {4'b0101, 1'b0, 8'h12}) begin
            n_err++;
            $display("FAIL or_byte1: got %h want 0101/0/12", {alu_s_o, alu_carry_o, alu_rs_o});
        end
        tick();
        n_vec++;
        if (rsp_res_o !== 32'h0000_1234 || {rsp_valid_o, rsp_z_o} !== 2'b10) begin
            n_err++;
            $display("FAIL or_rsp: got res=%h vz=%b want res=00001234 vz=10",
                     rsp_res_o, {rsp_valid_o, rsp_z_o});
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        issue(4'b0000, 2'd0, 32'h0000_007F, 32'h0000_0001, 3'd0, 1'b0);
        tick();
        cmd_valid_i = 1'b1;
        cmd_a_i     = 32'h0000_0055;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if ({rsp_valid_o, cmd_ready_o, busy_o} !== 3'b101 || rsp_res_o !== 32'h80
                || {rsp_z_o, rsp_c_o, rsp_v_o, rsp_n_o} !== 4'b0011) begin
                n_err++;
                $display("FAIL hold_%0d: got vrb=%b res=%h zcvn=%b want 101 00000080 0011", i,
                         {rsp_valid_o, cmd_ready_o, busy_o}, rsp_res_o,
                         {rsp_z_o, rsp_c_o, rsp_v_o, rsp_n_o});
            end
        end
        cmd_valid_i = 1'b0;
        handshake();
        tick();
        n_vec++;
        if ({busy_o, rsp_valid_o, cmd_ready_o} !== 3'b001) begin
            n_err++;
            $display("FAIL no_queue: got %b want 001", {busy_o, rsp_valid_o, cmd_ready_o});
        end
        issue(4'b0000, 2'd0, 32'h0000_0001, 32'h0000_0002, 3'd0, 1'b0);
        tick();
        n_vec++;
        if (rsp_res_o !== 32'h3 || rsp_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL next_cmd: got v=%b res=%h want v=1 res=00000003", rsp_valid_o, rsp_res_o);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        bit seen;
        issue(4'b0000, 2'd3, 32'h0102_0304, 32'h1020_3040, 3'd0, 1'b0);
        tick();
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        n_vec++;
        if ({busy_o, rsp_valid_o, cmd_ready_o, rsp_res_o} !== 35'h0) begin
            n_err++;
            $display("FAIL rst_mid_state: got %h want 0",
                     {busy_o, rsp_valid_o, cmd_ready_o, rsp_res_o});
        end
        n_vec++;
        if ({alu_rs_o, alu_op2_o, alu_s_o, alu_carry_o, alu_count_o} !== 24'h0) begin
            n_err++;
            $display("FAIL rst_mid_alu: got %h want 0",
                     {alu_rs_o, alu_op2_o, alu_s_o, alu_carry_o, alu_count_o});
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        n_vec++;
        if (cmd_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_ready: got %b want 1", cmd_ready_o);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid_o !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_no_rsp: got rsp_valid seen=%b want 0", seen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add2();
        test_shift();
        test_add4();
        test_logic();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
